// File: rtl/cga_intr_pkg.sv
// Shared types and constants for the CGA interrupt level resolver.
// Holds the handshake state enum, level type and the group-gate helper.
package cga_intr_pkg;

   localparam int LEV_W    = 4;
   localparam int NLEV     = 16;
   localparam int HIGRP_LO = 8;

   typedef logic [LEV_W-1:0] level_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      HOLD = 2'd2
   } state_t;

   // Level 0 never requests; the high group is masked while higsn is set.
   function automatic logic [NLEV-1:0] gate_mask(input logic higsn, input int lo);
      logic [NLEV-1:0] m;
      for (int i = 0; i < NLEV; i++) begin
         m[i] = (i != 0) && !(higsn && (i >= lo));
      end
      return m;
   endfunction

endpackage

// File: rtl/cga_intr_prio_enc.sv
// Combinational 16-to-4 highest-set-bit encoder with a valid flag.
module cga_intr_prio_enc
   import cga_intr_pkg::*;
(
   input  logic [NLEV-1:0] i_vec,
   output level_t          o_lev,
   output logic            o_vld
);

   // Scan upward so the highest set bit is the last one kept.
   always_comb begin
      o_lev = '0;
      o_vld = |i_vec;
      for (int i = 0; i < NLEV; i++) begin
         o_lev = i_vec[i] ? level_t'(i) : o_lev;
      end
   end

endmodule

// File: rtl/cga_intr_level_resolver.sv
// CGA interrupt level resolver: PID/PIE/PIL registers, priority resolution
// and the INTRN/ACKN handshake. Readback is built when CGA_INTR_READBACK_EN is defined.
module cga_intr_level_resolver #(
   parameter int NLEV     = 16,
   parameter int HIGRP_LO = 8
) (
   input  logic            MCLK,
   input  logic            RESETN,
   input  logic [15:0]     FIDB_IN,
   input  logic            LDPIDN,
   input  logic            LDPIEN,
   input  logic            LDPILN,
   input  logic            RDPIDN,
   input  logic            RDPIEN,
   input  logic            RDPILN,
   input  logic [NLEV-1:0] IRQSET,
   input  logic            HIGSN,
   input  logic            IONN,
   input  logic            ACKN,
   output logic            INTRN,
   output logic [3:0]      ILEV,
   output logic [3:0]      PIL,
   output logic [15:0]     FIDB_OUT,
   output logic            FIDB_OE
);

   import cga_intr_pkg::*;

   logic [NLEV-1:0] r_pid;
   logic [NLEV-1:0] r_pie;
   level_t          r_pil;
   level_t          r_ilev;
   state_t          r_state;
   logic            r_intrn;

   logic [NLEV-1:0] w_eff;
   level_t          w_cand;
   logic            w_cand_vld;
   logic            w_cand_ok;
   logic            w_withdraw;

   assign w_eff      = r_pid & r_pie & gate_mask(HIGSN, HIGRP_LO);
   assign w_cand_ok  = w_cand_vld && (w_cand > r_pil) && !IONN;
   assign w_withdraw = !w_eff[r_ilev] || IONN || (w_cand_vld && (w_cand > r_ilev));

   cga_intr_prio_enc u_prio_enc (
      .i_vec (w_eff),
      .o_lev (w_cand),
      .o_vld (w_cand_vld)
   );

   // Hardware sets are ORed after the software load so a same-cycle set survives.
   always_ff @(posedge MCLK) begin
      if (!RESETN) begin
         r_pid <= '0;
         r_pie <= '0;
      end else begin
         r_pid <= (LDPIDN ? r_pid : FIDB_IN) | IRQSET;
         r_pie <= LDPIEN ? r_pie : FIDB_IN;
      end
   end

   // Request/acknowledge handshake; acknowledge takes precedence over withdraw.
   always_ff @(posedge MCLK) begin
      if (!RESETN) begin
         r_state <= IDLE;
         r_pil   <= '0;
         r_ilev  <= '0;
         r_intrn <= 1'b1;
      end else begin
         case (r_state)
            IDLE: begin
               if (!LDPILN) begin
                  r_pil <= FIDB_IN[3:0];
               end
               if (w_cand_ok) begin
                  r_ilev  <= w_cand;
                  r_intrn <= 1'b0;
                  r_state <= REQ;
               end else begin
                  r_intrn <= 1'b1;
               end
            end
            REQ: begin
               if (!ACKN) begin
                  r_pil   <= r_ilev;
                  r_intrn <= 1'b1;
                  r_state <= HOLD;
               end else if (w_withdraw) begin
                  r_intrn <= 1'b1;
                  r_state <= IDLE;
               end else begin
                  r_intrn <= 1'b0;
               end
            end
            HOLD: begin
               if (!LDPILN) begin
                  r_pil <= FIDB_IN[3:0];
               end
               r_intrn <= 1'b1;
               r_state <= IDLE;
            end
            default: begin
               r_intrn <= 1'b1;
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign INTRN = r_intrn;
   assign ILEV  = r_ilev;
   assign PIL   = r_pil;

`ifdef CGA_INTR_READBACK_EN
   logic [15:0] r_fidb_out;
   logic        r_fidb_oe;

   // Registered readback of pre-write values; PID beats PIE beats PIL.
   always_ff @(posedge MCLK) begin
      if (!RESETN) begin
         r_fidb_out <= 16'h0000;
         r_fidb_oe  <= 1'b0;
      end else begin
         r_fidb_oe <= !(RDPIDN && RDPIEN && RDPILN);
         if (!RDPIDN) begin
            r_fidb_out <= r_pid;
         end else if (!RDPIEN) begin
            r_fidb_out <= r_pie;
         end else if (!RDPILN) begin
            r_fidb_out <= {12'h000, r_pil};
         end else begin
            r_fidb_out <= 16'h0000;
         end
      end
   end

   assign FIDB_OUT = r_fidb_out;
   assign FIDB_OE  = r_fidb_oe;
`else
   logic w_unused_rd;

   assign w_unused_rd = ^{RDPIDN, RDPIEN, RDPILN};
   assign FIDB_OUT    = 16'h0000;
   assign FIDB_OE     = 1'b0;
`endif

endmodule

// File: tb/tb_cga_intr_level_resolver.sv
// Self-checking bench for cga_intr_level_resolver: directed scenarios plus
// randomized traffic compared against a cycle-level behavioural model.
module tb_cga_intr_level_resolver;

`ifdef CGA_INTR_READBACK_EN
   localparam bit RB_EN = 1'b1;
`else
   localparam bit RB_EN = 1'b0;
`endif

   logic        MCLK = 1'b0;
   logic        RESETN, LDPIDN, LDPIEN, LDPILN, RDPIDN, RDPIEN, RDPILN;
   logic        HIGSN, IONN, ACKN;
   logic [15:0] FIDB_IN, IRQSET;
   logic        INTRN, FIDB_OE;
   logic [3:0]  ILEV, PIL;
   logic [15:0] FIDB_OUT;

   int total = 0;
   int bad   = 0;

   // Behavioural model state: mode 0 = quiet, 1 = requesting, 2 = settling.
   logic [15:0] m_pid = 16'h0000, m_pie = 16'h0000, m_fout = 16'h0000;
   logic [3:0]  m_pil = 4'h0, m_ilev = 4'h0;
   logic        m_oe = 1'b0;
   int          m_mode = 0;

   always #5 MCLK = ~MCLK;

   cga_intr_level_resolver dut (
      .MCLK(MCLK), .RESETN(RESETN), .FIDB_IN(FIDB_IN),
      .LDPIDN(LDPIDN), .LDPIEN(LDPIEN), .LDPILN(LDPILN),
      .RDPIDN(RDPIDN), .RDPIEN(RDPIEN), .RDPILN(RDPILN),
      .IRQSET(IRQSET), .HIGSN(HIGSN), .IONN(IONN), .ACKN(ACKN),
      .INTRN(INTRN), .ILEV(ILEV), .PIL(PIL),
      .FIDB_OUT(FIDB_OUT), .FIDB_OE(FIDB_OE)
   );

   function automatic logic [15:0] eff_of(input logic [15:0] pid, input logic [15:0] pie,
                                          input logic higsn);
      logic [15:0] e;
      for (int i = 0; i < 16; i++) begin
         e[i] = pid[i] && pie[i] && (i != 0) && !(higsn && i >= 8);
      end
      return e;
   endfunction

   function automatic int top_level(input logic [15:0] v);
      int t = -1;
      for (int i = 0; i < 16; i++) begin
         if (v[i]) t = i;
      end
      return t;
   endfunction

   task automatic model_step();
      logic [15:0] e;
      int          c, nm;
      logic [3:0]  np;
      e = eff_of(m_pid, m_pie, HIGSN);
      c = top_level(e);
      if (!RESETN) begin
         m_pid = 16'h0000; m_pie = 16'h0000; m_pil = 4'h0; m_ilev = 4'h0;
         m_mode = 0; m_fout = 16'h0000; m_oe = 1'b0;
         return;
      end
      m_oe = RB_EN && (!RDPIDN || !RDPIEN || !RDPILN);
      if (!RB_EN)       m_fout = 16'h0000;
      else if (!RDPIDN) m_fout = m_pid;
      else if (!RDPIEN) m_fout = m_pie;
      else if (!RDPILN) m_fout = {12'h000, m_pil};
      else              m_fout = 16'h0000;
      np = m_pil;
      nm = m_mode;
      if (m_mode == 1) begin
         if (!ACKN) begin
            np = m_ilev; nm = 2;
         end else if (!e[m_ilev] || IONN || c > int'(m_ilev)) begin
            nm = 0;
         end
      end else begin
         if (!LDPILN) np = FIDB_IN[3:0];
         if (m_mode == 2) nm = 0;
         else if (c > 0 && c > int'(m_pil) && !IONN) begin
            m_ilev = 4'(c); nm = 1;
         end
      end
      m_pid  = (LDPIDN ? m_pid : FIDB_IN) | IRQSET;
      m_pie  = LDPIEN ? m_pie : FIDB_IN;
      m_pil  = np;
      m_mode = nm;
   endtask

   task automatic tick();
      model_step();
      @(posedge MCLK);
      #1;
   endtask

   task automatic quiet();
      LDPIDN = 1'b1; LDPIEN = 1'b1; LDPILN = 1'b1;
      RDPIDN = 1'b1; RDPIEN = 1'b1; RDPILN = 1'b1;
      ACKN = 1'b1; IRQSET = 16'h0000; FIDB_IN = 16'h0000;
   endtask

   task automatic test_reset();
      quiet(); HIGSN = 1'b0; IONN = 1'b0; RESETN = 1'b0;
      tick(); tick();
      RESETN = 1'b1;
      total++; if (INTRN !== 1'b1) begin bad++; $display("FAIL reset_intrn got=%0b want=1", INTRN); end
      total++; if (ILEV !== 4'h0) begin bad++; $display("FAIL reset_ilev got=%0d want=0", ILEV); end
      total++; if (PIL !== 4'h0) begin bad++; $display("FAIL reset_pil got=%0d want=0", PIL); end
      total++; if (FIDB_OUT !== 16'h0000 || FIDB_OE !== 1'b0) begin
         bad++; $display("FAIL reset_rb got=%h/%0b want=0000/0", FIDB_OUT, FIDB_OE); end
   endtask

   task automatic test_basic_request();
      LDPIEN = 1'b0; FIDB_IN = 16'hFFFF; tick(); quiet();
      LDPIDN = 1'b0; FIDB_IN = 16'h0020; tick(); quiet();
      total++; if (INTRN !== 1'b1) begin bad++; $display("FAIL basic_early got=%0b want=1", INTRN); end
      tick();
      total++; if (INTRN !== 1'b0 || ILEV !== 4'd5) begin
         bad++; $display("FAIL basic_req got=%0b/%0d want=0/5", INTRN, ILEV); end
      ACKN = 1'b0; tick(); ACKN = 1'b1;
      total++; if (PIL !== 4'd5 || INTRN !== 1'b1) begin
         bad++; $display("FAIL basic_ack got=%0d/%0b want=5/1", PIL, INTRN); end
      tick(); tick();
      total++; if (INTRN !== 1'b1) begin bad++; $display("FAIL basic_after got=%0b want=1", INTRN); end
   endtask

   task automatic test_high_gate();
      HIGSN = 1'b1; IRQSET = 16'h1000; tick(); IRQSET = 16'h0000; tick(); tick();
      total++; if (INTRN !== 1'b1) begin bad++; $display("FAIL gate_masked got=%0b want=1", INTRN); end
      HIGSN = 1'b0; tick();
      total++; if (INTRN !== 1'b0 || ILEV !== 4'd12) begin
         bad++; $display("FAIL gate_open got=%0b/%0d want=0/12", INTRN, ILEV); end
      ACKN = 1'b0; tick(); ACKN = 1'b1;
      total++; if (PIL !== 4'd12) begin bad++; $display("FAIL gate_ack got=%0d want=12", PIL); end
      tick();
      LDPIDN = 1'b0; FIDB_IN = 16'h0000; tick(); quiet();
   endtask

   task automatic test_withdraw();
      LDPILN = 1'b0; FIDB_IN = 16'h0000; tick(); quiet();
      LDPIDN = 1'b0; FIDB_IN = 16'h0008; tick(); quiet();
      tick();
      total++; if (INTRN !== 1'b0 || ILEV !== 4'd3) begin
         bad++; $display("FAIL wd_req3 got=%0b/%0d want=0/3", INTRN, ILEV); end
      IRQSET = 16'h0200; tick(); IRQSET = 16'h0000;
      tick();
      total++; if (INTRN !== 1'b1) begin bad++; $display("FAIL wd_withdraw got=%0b want=1", INTRN); end
      tick();
      total++; if (INTRN !== 1'b0 || ILEV !== 4'd9) begin
         bad++; $display("FAIL wd_rereq got=%0b/%0d want=0/9", INTRN, ILEV); end
      ACKN = 1'b0; tick(); ACKN = 1'b1;
      tick();
   endtask

   task automatic test_pid_collision();
      logic [15:0] exp_rb;
      LDPIDN = 1'b0; FIDB_IN = 16'h0000; IRQSET = 16'h0080; tick(); quiet();
      total++; if (INTRN !== 1'b1) begin bad++; $display("FAIL coll_quiet got=%0b want=1", INTRN); end
      RDPIDN = 1'b0; tick(); RDPIDN = 1'b1;
      exp_rb = RB_EN ? 16'h0080 : 16'h0000;
      total++; if (FIDB_OUT !== exp_rb) begin
         bad++; $display("FAIL coll_rb got=%h want=%h", FIDB_OUT, exp_rb); end
      LDPILN = 1'b0; FIDB_IN = 16'h0000; tick(); quiet();
      tick();
      total++; if (INTRN !== 1'b0 || ILEV !== 4'd7) begin
         bad++; $display("FAIL coll_req got=%0b/%0d want=0/7", INTRN, ILEV); end
   endtask

   task automatic test_ack_beats_withdraw();
      ACKN = 1'b0; LDPIEN = 1'b0; FIDB_IN = 16'hFF7F; tick(); quiet();
      total++; if (PIL !== 4'd7 || INTRN !== 1'b1) begin
         bad++; $display("FAIL ackwin got=%0d/%0b want=7/1", PIL, INTRN); end
      tick();
      LDPILN = 1'b0; FIDB_IN = 16'h0000; tick(); quiet();
      tick();
      total++; if (INTRN !== 1'b1) begin bad++; $display("FAIL ackwin_pie got=%0b want=1", INTRN); end
   endtask

   task automatic test_reset_midreq();
      LDPIEN = 1'b0; FIDB_IN = 16'hFFFF; tick(); quiet();
      tick();
      total++; if (INTRN !== 1'b0) begin bad++; $display("FAIL rstmid_req got=%0b want=0", INTRN); end
      RESETN = 1'b0; ACKN = 1'b0; tick(); RESETN = 1'b1; ACKN = 1'b1;
      total++; if (INTRN !== 1'b1 || PIL !== 4'd0 || ILEV !== 4'd0) begin
         bad++; $display("FAIL rstmid got=%0b/%0d/%0d want=1/0/0", INTRN, PIL, ILEV); end
   endtask

   task automatic test_readback();
      logic [15:0] e_out;
      logic        e_oe;
      IONN = 1'b1;
      LDPIDN = 1'b0; FIDB_IN = 16'h1234; tick(); quiet();
      LDPIEN = 1'b0; FIDB_IN = 16'h00F0; tick(); quiet();
      LDPILN = 1'b0; FIDB_IN = 16'h000A; tick(); quiet();
      e_oe = RB_EN;
      RDPIDN = 1'b0; RDPIEN = 1'b0; tick(); quiet();
      e_out = RB_EN ? 16'h1234 : 16'h0000;
      total++; if (FIDB_OUT !== e_out || FIDB_OE !== e_oe) begin
         bad++; $display("FAIL rb_pid got=%h/%0b want=%h/%0b", FIDB_OUT, FIDB_OE, e_out, e_oe); end
      RDPIEN = 1'b0; RDPILN = 1'b0; tick(); quiet();
      e_out = RB_EN ? 16'h00F0 : 16'h0000;
      total++; if (FIDB_OUT !== e_out || FIDB_OE !== e_oe) begin
         bad++; $display("FAIL rb_pie got=%h/%0b want=%h/%0b", FIDB_OUT, FIDB_OE, e_out, e_oe); end
      RDPILN = 1'b0; tick(); quiet();
      e_out = RB_EN ? 16'h000A : 16'h0000;
      total++; if (FIDB_OUT !== e_out || FIDB_OE !== e_oe) begin
         bad++; $display("FAIL rb_pil got=%h/%0b want=%h/%0b", FIDB_OUT, FIDB_OE, e_out, e_oe); end
      RDPIDN = 1'b0; LDPIDN = 1'b0; FIDB_IN = 16'h5555; tick(); quiet();
      e_out = RB_EN ? 16'h1234 : 16'h0000;
      total++; if (FIDB_OUT !== e_out) begin
         bad++; $display("FAIL rb_prewrite got=%h want=%h", FIDB_OUT, e_out); end
      tick();
      total++; if (FIDB_OUT !== 16'h0000 || FIDB_OE !== 1'b0) begin
         bad++; $display("FAIL rb_idle got=%h/%0b want=0000/0", FIDB_OUT, FIDB_OE); end
      IONN = 1'b0;
   endtask

   task automatic test_random();
      for (int n = 0; n < 600; n++) begin
         RESETN  = ($urandom_range(0, 79) != 0);
         LDPIDN  = ($urandom_range(0, 7) != 0);
         LDPIEN  = ($urandom_range(0, 7) != 0);
         LDPILN  = ($urandom_range(0, 5) != 0);
         RDPIDN  = ($urandom_range(0, 4) != 0);
         RDPIEN  = ($urandom_range(0, 4) != 0);
         RDPILN  = ($urandom_range(0, 4) != 0);
         FIDB_IN = 16'($urandom);
         IRQSET  = ($urandom_range(0, 2) == 0) ? 16'(32'd1 << $urandom_range(0, 15)) : 16'h0000;
         HIGSN   = ($urandom_range(0, 3) == 0);
         IONN    = ($urandom_range(0, 9) == 0);
         ACKN    = ($urandom_range(0, 2) != 0);
         tick();
         total++; if (INTRN !== (m_mode != 1)) begin
            bad++; $display("FAIL rnd_intrn cyc=%0d got=%0b want=%0b", n, INTRN, m_mode != 1); end
         total++; if (PIL !== m_pil) begin
            bad++; $display("FAIL rnd_pil cyc=%0d got=%0d want=%0d", n, PIL, m_pil); end
         total++; if (FIDB_OUT !== m_fout || FIDB_OE !== m_oe) begin
            bad++; $display("FAIL rnd_rb cyc=%0d got=%h/%0b want=%h/%0b", n, FIDB_OUT, FIDB_OE, m_fout, m_oe); end
         if (m_mode == 1) begin
            total++; if (ILEV !== m_ilev) begin
               bad++; $display("FAIL rnd_ilev cyc=%0d got=%0d want=%0d", n, ILEV, m_ilev); end
         end
      end
      quiet(); RESETN = 1'b1;
   endtask

   initial begin
      test_reset();
      test_basic_request();
      test_high_gate();
      test_withdraw();
      test_pid_collision();
      test_ack_beats_withdraw();
      test_reset_midreq();
      test_readback();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
